// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute-stage ALU between decode and writeback. Takes one operation per
//   in_valid/in_ready handshake. The result, branch decision and illegal-code
//   flag are held until the out_valid/out_ready handshake completes.
//   By default shifts run iteratively, one bit per cycle. Build with
//   ALU_BARREL_SHIFT_EN defined to compute shifts in a single cycle. Both
//   builds produce the same results.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready input handshake; in_ready is high only in IDLE
//   alu_ctrl [4:0]    decoder operation code
//   op_a, op_b        operands, sampled only when an operation is accepted
//   out_valid/out_ready  output handshake; outputs hold while stalled
//   result            ALU result
//   branch_taken      branch condition (branch codes only)
//   illegal_op        alu_ctrl was an unassigned code
//
// state | meaning
// IDLE  | waiting for an operation; in_ready=1
// SHIFT | iterative shift: one bit per cycle, cnt_q holds the bits remaining
// DONE  | out_valid=1, outputs held until out_ready
module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch_taken,
    output logic            illegal_op
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shift_t;

    state_t          state_q, state_d;
    shift_t          kind_q, kind_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            taken_q, taken_d;
    logic            illegal_q, illegal_d;

    logic [XLEN-1:0] dec_res;
    logic            dec_taken;
    logic            dec_illegal;
    logic            dec_shift;
    shift_t          dec_kind;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] acc_step;
    logic [SHW-1:0]  shamt;
    logic            lt_s, lt_u, eq;

    assign shamt = op_b[SHW-1:0];
    assign sum   = op_a + op_b;
    assign lt_s  = $signed(op_a) < $signed(op_b);
    assign lt_u  = op_a < op_b;
    assign eq    = op_a == op_b;

    always_comb begin
        dec_res     = '0;
        dec_taken   = 1'b0;
        dec_illegal = 1'b0;
        dec_shift   = 1'b0;
        dec_kind    = SH_SLL;
        unique case (alu_ctrl)
            5'b00000: dec_res = sum;
            5'b00001: dec_res = op_b;
            5'b00010: dec_res = op_a - op_b;
            5'b00011: dec_res = {sum[XLEN-1:1], 1'b0};
            5'b00100: dec_res = {{(XLEN-1){1'b0}}, lt_u};
            5'b00101: dec_res = op_a ^ op_b;
            5'b00110: dec_res = op_a | op_b;
            5'b00111: dec_res = op_a & op_b;
            5'b01000, 5'b10011: begin dec_shift = 1'b1; dec_kind = SH_SLL; end
            5'b01010, 5'b10101: begin dec_shift = 1'b1; dec_kind = SH_SRL; end
            5'b01001, 5'b10100: begin dec_shift = 1'b1; dec_kind = SH_SRA; end
            5'b01100: dec_res = {{(XLEN-1){1'b0}}, lt_s};
            5'b01101: dec_taken = eq;
            5'b10010: dec_taken = !eq;
            5'b10000: dec_taken = lt_s;
            5'b01110: dec_taken = !lt_s;
            5'b10001: dec_taken = lt_u;
            5'b01111: dec_taken = !lt_u;
            5'b10110: dec_res = op_a | op_b;
            5'b10111: dec_res = op_a;
            default:  dec_illegal = 1'b1;
        endcase
        if (dec_taken) begin
            dec_res = {{(XLEN-1){1'b0}}, 1'b1};
        end
`ifdef ALU_BARREL_SHIFT_EN
        if (dec_shift) begin
            unique case (dec_kind)
                SH_SRL:  dec_res = op_a >> shamt;
                SH_SRA:  dec_res = XLEN'($signed(op_a) >>> shamt);
                default: dec_res = op_a << shamt;
            endcase
        end
`endif
    end

    always_comb begin
        unique case (kind_q)
            SH_SRL:  acc_step = {1'b0, acc_q[XLEN-1:1]};
            SH_SRA:  acc_step = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
            default: acc_step = {acc_q[XLEN-2:0], 1'b0};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    result_d  = dec_res;
                    taken_d   = dec_taken;
                    illegal_d = dec_illegal;
                    state_d   = DONE;
`ifndef ALU_BARREL_SHIFT_EN
                    if (dec_shift) begin
                        // shamt==0 completes with a unchanged
                        result_d = op_a;
                        if (shamt != '0) begin
                            state_d = SHIFT;
                            acc_d   = op_a;
                            cnt_d   = shamt;
                            kind_d  = dec_kind;
                        end
                    end
`endif
                end
            end
            SHIFT: begin
                acc_d = acc_step;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    result_d = acc_step;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            kind_q    <= SH_SLL;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign result       = result_q;
    assign branch_taken = taken_q;
    assign illegal_op   = illegal_q;

endmodule
